// File: rtl/log2_pkg.sv
// ---------------------------------------------------------------------------
// log2_pkg
// Shared definitions for the serial floor-log2 unit:
//   WIDTH  - default operand width in bits
//   LOG_W  - width of the log2 result for the default operand width
//   state_t - controller states (IDLE, BUSY, DONE)
// ---------------------------------------------------------------------------
package log2_pkg;

    localparam int WIDTH = 8;
    localparam int LOG_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/log2_serial.sv
// ---------------------------------------------------------------------------
// log2_serial
// Serial floor(log2 n) unit. An accepted operand is shifted right one bit per
// cycle until only its top set bit remains at position 0. The shift count is
// then floor(log2 n), and a sticky flag records whether any lower bit was
// shifted out, which tells us whether n was a power of two.
//
// Optional feature (macro LOG2_SERIAL_CEIL_EN): adds output log2_ceil, the
// ceiling of log2 n (0 for n == 0).
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst        in   asynchronous active-high reset
//   n          in   [WIDTH-1:0] operand, sampled on the accept edge
//   in_valid   in   operand present
//   in_ready   out  high in IDLE while not in reset
//   log2       out  [$clog2(WIDTH)-1:0] floor(log2 n)
//   is_pow2    out  n was a non-zero power of two
//   zero       out  n was zero
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer takes the result
//   log2_ceil  out  [$clog2(WIDTH):0] ceil(log2 n) (LOG2_SERIAL_CEIL_EN only)
// ---------------------------------------------------------------------------
module log2_serial #(
    parameter int WIDTH = log2_pkg::WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         n,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [$clog2(WIDTH)-1:0] log2,
    output logic                     is_pow2,
    output logic                     zero,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef LOG2_SERIAL_CEIL_EN
    ,
    output logic [$clog2(WIDTH):0]   log2_ceil
`endif
);

    import log2_pkg::*;

    localparam int LW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [LW-1:0]    cnt;
    logic             lost;

    // Ready is purely a function of the state, masked while reset is held so
    // nobody believes an operand was taken during reset.
    assign in_ready = (state == IDLE) && !rst;

    // Controller and datapath. Result registers only change when entering
    // DONE, so they naturally hold their last values in IDLE and BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            lost      <= 1'b0;
            log2      <= '0;
            is_pow2   <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
`ifdef LOG2_SERIAL_CEIL_EN
            log2_ceil <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh   <= n;
                        cnt  <= '0;
                        lost <= 1'b0;
                        if (n == '0) begin
                            // Zero has no logarithm; report it directly.
                            state     <= DONE;
                            log2      <= '0;
                            is_pow2   <= 1'b0;
                            zero      <= 1'b1;
                            out_valid <= 1'b1;
`ifdef LOG2_SERIAL_CEIL_EN
                            log2_ceil <= '0;
`endif
                        end else begin
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    if (sh[WIDTH-1:1] != '0) begin
                        sh   <= sh >> 1;
                        cnt  <= cnt + LW'(1);
                        lost <= lost | sh[0];
                    end else begin
                        state     <= DONE;
                        log2      <= cnt;
                        is_pow2   <= !lost;
                        zero      <= 1'b0;
                        out_valid <= 1'b1;
`ifdef LOG2_SERIAL_CEIL_EN
                        // Any discarded set bit means n lies strictly above
                        // 2^cnt, so the ceiling is one higher.
                        log2_ceil <= {1'b0, cnt} + {{LW{1'b0}}, lost};
`endif
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log2_serial.sv
// ---------------------------------------------------------------------------
// tb_log2_serial
// Self-checking bench for log2_serial (WIDTH = 8). Directed cases cover the
// documented examples, including reset during BUSY; randomized operands are
// then checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_log2_serial;

    localparam int W  = 8;
    localparam int LW = $clog2(W);

    logic          clk;
    logic          rst;
    logic [W-1:0]  n;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] log2;
    logic          is_pow2;
    logic          zero;
    logic          out_valid;
    logic          out_ready;
`ifdef LOG2_SERIAL_CEIL_EN
    logic [LW:0]   log2_ceil;
`endif

    int assert_count = 0;
    int fail_count   = 0;

    log2_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .n         (n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .log2      (log2),
        .is_pow2   (is_pow2),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef LOG2_SERIAL_CEIL_EN
        ,
        .log2_ceil (log2_ceil)
`endif
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input int got, input int exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model from the mathematical definition: largest k with
    // 2^k <= v, smallest c with 2^c >= v, and the expected number of edges
    // from the accept edge (inclusive) until out_valid is seen.
    task automatic ref_model(input int v, output int lg, output int p2,
                             output int z, output int cl, output int lat);
        lg = 0;
        cl = 0;
        z  = (v == 0) ? 1 : 0;
        p2 = 0;
        if (v != 0) begin
            while ((2 ** (lg + 1)) <= v) lg++;
            while ((2 ** cl) < v) cl++;
            p2 = ((2 ** lg) == v) ? 1 : 0;
        end
        lat = (v == 0) ? 1 : lg + 2;
    endtask

    // Runs one complete transaction: accept, wait for the result with random
    // in_valid noise, hold off the consumer for ready_delay cycles, then hand
    // off and confirm the return to IDLE with results held.
    task automatic apply_stimulus(input int v, input int ready_delay, input bit early_ready);
        int lg, p2, z, cl, lat, edges;
        ref_model(v, lg, p2, z, cl, lat);

        @(negedge clk);
        n         = W'(v);
        in_valid  = 1'b1;
        out_ready = early_ready;
        check_output($sformatf("in_ready_idle n=%0d", v), int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges    = 1;
        while (!out_valid && edges < 100) begin
            check_output("in_ready_busy", int'(in_ready), 0);
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            edges++;
        end
        in_valid = 1'b0;
        check_output($sformatf("latency n=%0d", v), edges, lat);
        check_output($sformatf("log2 n=%0d", v), int'(log2), lg);
        check_output($sformatf("is_pow2 n=%0d", v), int'(is_pow2), p2);
        check_output($sformatf("zero n=%0d", v), int'(zero), z);
`ifdef LOG2_SERIAL_CEIL_EN
        check_output($sformatf("log2_ceil n=%0d", v), int'(log2_ceil), cl);
`endif

        if (ready_delay > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < ready_delay; i++) begin
                in_valid = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                check_output("hold_valid", int'(out_valid), 1);
                check_output("hold_log2", int'(log2), lg);
                check_output("hold_pow2", int'(is_pow2), p2);
                check_output("hold_zero", int'(zero), z);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end else begin
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check_output("handoff_valid", int'(out_valid), 0);
        check_output("handoff_in_ready", int'(in_ready), 1);
        check_output("idle_log2_held", int'(log2), lg);
        check_output("idle_pow2_held", int'(is_pow2), p2);
        out_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int v, d;
        rst       = 1'b1;
        n         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_in_ready", int'(in_ready), 0);
        check_output("rst_out_valid", int'(out_valid), 0);
        check_output("rst_log2", int'(log2), 0);
        check_output("rst_pow2", int'(is_pow2), 0);
        check_output("rst_zero", int'(zero), 0);
        rst = 1'b0;
        #1;
        check_output("post_rst_in_ready", int'(in_ready), 1);

        // Documented examples.
        apply_stimulus(64, 0, 1'b1);
        apply_stimulus(255, 2, 1'b0);
        apply_stimulus(0, 0, 1'b1);
        apply_stimulus(128, 5, 1'b0);

        // Reset during the second BUSY cycle discards the result.
        @(negedge clk);
        n        = 8'd8;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check_output("midrst_out_valid", int'(out_valid), 0);
        check_output("midrst_log2", int'(log2), 0);
        check_output("midrst_pow2", int'(is_pow2), 0);
        check_output("midrst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check_output("midrst_release_in_ready", int'(in_ready), 1);
        repeat (4) begin
            @(posedge clk);
            #1;
            check_output("midrst_no_valid", int'(out_valid), 0);
        end
        apply_stimulus(1, 1, 1'b0);

        // Randomized operands, biased toward powers of two and zero.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0:       v = 1 << $urandom_range(0, W - 1);
                1:       v = 0;
                default: v = $urandom_range(0, (1 << W) - 1);
            endcase
            d = $urandom_range(0, 3);
            apply_stimulus(v, d, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #500000;
        fail_count++;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/log2_serial.md
LOG2_SERIAL -- requirements
Module: log2_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 n  input  WIDTH  operand; sampled only on the accept edge.
REQ-005 in_valid  input  1  operand present.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 log2  output  $clog2(WIDTH)  floor(log2 n).
REQ-008 is_pow2  output  1  n is a non-zero power of two.
REQ-009 zero  output  1  n was 0.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes the result.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE; in_ready = (state==IDLE) and not rst.
REQ-013 Accept SHALL occur on an edge with in_valid and in_ready high: latch n into shift register sh, clear count cnt, clear sticky flag lost.
REQ-014 Accept with n==0 SHALL go directly to DONE: zero=1, log2=0, is_pow2=0, out_valid high the next cycle.
REQ-015 Accept with n!=0 SHALL go to BUSY.
REQ-016 BUSY, sh[WIDTH-1:1]!=0: sh>>=1, cnt+=1, lost|=sh[0]; stay in BUSY.
REQ-017 BUSY, sh[WIDTH-1:1]==0: go to DONE; log2=cnt, is_pow2=not lost, zero=0.
REQ-018 Latency for n!=0 SHALL be exactly floor(log2 n)+1 cycles in BUSY (n=1: one cycle; n=2^(WIDTH-1): WIDTH cycles).
REQ-019 DONE: out_valid=1; log2, is_pow2 and zero SHALL be held stable until out_valid and out_ready are both high on an edge, then go to IDLE.
REQ-020 in_valid SHALL be ignored in BUSY and DONE; no back-to-back accept; the earliest new accept is the first IDLE cycle after handoff.
REQ-021 out_ready SHALL be ignored outside DONE.
REQ-022 Result outputs SHALL hold their last values in IDLE and BUSY; consumers qualify them with out_valid only.

Reset
REQ-023 rst high SHALL force state=IDLE, out_valid=0, log2=0, is_pow2=0, zero=0, sh=0, cnt=0, lost=0, at any time including mid-BUSY or DONE.
REQ-024 Any in-flight result SHALL be discarded without handoff; the first accept is allowed on the first edge after rst deasserts.

Configuration
REQ-025 Macro LOG2_SERIAL_CEIL_EN defined: extra output log2_ceil [$clog2(WIDTH):0] = log2 + (is_pow2 ? 0 : 1); for n==0, log2_ceil=0; timing, reset and hold rules same as log2.
REQ-026 LOG2_SERIAL_CEIL_EN undefined: no log2_ceil port and no related logic; all other behaviour unchanged.

Structure
REQ-027 Shared package log2_pkg SHALL hold default WIDTH=8, LOG_W=$clog2(WIDTH) and the state enum (IDLE, BUSY, DONE).
REQ-028 Single flat module; no sub-module.

Verification
REQ-029 n=8'b01000000, out_ready=1 -> 7 BUSY cycles, log2=6, is_pow2=1, zero=0 (ceil=6).
REQ-030 n=8'b11111111 -> 8 BUSY cycles, log2=7, is_pow2=0 (ceil=8).
REQ-031 n=0 -> out_valid one cycle after accept, zero=1, log2=0, is_pow2=0 (ceil=0).
REQ-032 n=8'b10000000, out_ready low 5 cycles in DONE -> outputs stable log2=7, is_pow2=1; IDLE one edge after out_ready rises; in_valid pulses during BUSY/DONE ignored.
REQ-033 n=8'b00001000, rst pulsed in 2nd BUSY cycle -> out_valid never rises, outputs 0, in_ready=1 after release; next n=1 -> log2=0, is_pow2=1 after 1 BUSY cycle.
